// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
//   Word-level handshake bundle between a TX source (host FSM or TX FIFO) and
//   the uart_tx_param transmitter. The per-frame configuration travels with
//   the word because it is sampled on the same accept edge.
//
// Signals
//   tx_data     DATA_BITS  word to send
//   tx_valid    1          source has a word
//   tx_ready    1          transmitter can take a word (idle)
//   set_baud    3          baud select: 0=9600 1=19200 2=38400 3=57600
//                          4=115200, 5..7 -> 9600
//   parity_mode 2          00 none, 01 even, 10 odd, 11 none
//   stop2       1          0 = one stop bit, 1 = two stop bits
//
// Modports
//   master  source side (drives word and configuration, reads tx_ready)
//   slave   transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [2:0]           set_baud;
    logic [1:0]           parity_mode;
    logic                 stop2;

    modport master (
        output tx_data, tx_valid, set_baud, parity_mode, stop2,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, set_baud, parity_mode, stop2,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//   Parametrised UART transmitter. One word per ready/valid handshake, baud
//   rate, parity mode and stop-bit count chosen per frame at accept time.
//   Frame: start(0), DATA_BITS data bits LSB first, optional parity, 1 or 2
//   stop bits. Every bit is held DIV = CLK_FREQ / baud clock cycles.
//
// Build option
//   UART_TX_PARITY_EN  defined   : PARITY state and parity logic are built.
//                      undefined : parity_mode is ignored, no parity bit sent.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   DATA_BITS  word width, 5..9
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active high; abandons a frame in flight
//   bus      uart_tx_param_if.slave: tx_data/tx_valid/tx_ready plus the
//            per-frame set_baud/parity_mode/stop2 configuration
//   tx       registered serial line, idle high
//   tx_done  one-cycle pulse in the final line cycle of a frame
//   busy     inverse of tx_ready
//
// Timing
//   The start bit is on the line in the first cycle after accept. The last
//   cycle of the stop period is spent in IDLE with tx_done high, so a word
//   accepted on that edge starts its start bit with no idle gap and the frame
//   period stays exactly (1 + DATA_BITS + P + S) * DIV cycles.
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_BITS = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_param_if.slave bus,
    output logic           tx,
    output logic           tx_done,
    output logic           busy
);

    localparam int DIV_9600   = CLK_FREQ / 9600;
    localparam int DIV_19200  = CLK_FREQ / 19200;
    localparam int DIV_38400  = CLK_FREQ / 38400;
    localparam int DIV_57600  = CLK_FREQ / 57600;
    localparam int DIV_115200 = CLK_FREQ / 115200;

    // 9600 baud always gives the largest divisor; the counter only ever has
    // to reach DIV-1, so $clog2(DIV) bits are enough.
    localparam int CNT_W = (DIV_9600 > 1) ? $clog2(DIV_9600) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [BIT_W-1:0] bit_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Divisor minus one, so it fits the counter even when DIV is a power of 2.
    function automatic cnt_t div_m1(input logic [2:0] sel);
        case (sel)
            3'd1:    return cnt_t'(DIV_19200 - 1);
            3'd2:    return cnt_t'(DIV_38400 - 1);
            3'd3:    return cnt_t'(DIV_57600 - 1);
            3'd4:    return cnt_t'(DIV_115200 - 1);
            default: return cnt_t'(DIV_9600 - 1);
        endcase
    endfunction

    // Architectural state
    state_t               r_state;
    cnt_t                 r_cnt;
    cnt_t                 r_div_m1;
    logic [DATA_BITS-1:0] r_shift;
    bit_idx_t             r_bit_idx;
    logic                 r_stop2;
    logic                 r_stop_more;  // another stop bit follows the current one
    logic                 r_tx;
    logic                 r_tx_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_par_en;
    logic                 r_par_bit;
`endif

    // Next-state values
    state_t               w_state_next;
    cnt_t                 w_cnt_next;
    logic [DATA_BITS-1:0] w_shift_next;
    bit_idx_t             w_bit_next;
    logic                 w_stop_more_next;
    logic                 w_tx_next;
    logic                 w_done_next;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_last_data;

    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_idle && bus.tx_valid;
    assign w_bit_end   = (r_cnt == r_div_m1);
    assign w_last_data = (r_bit_idx == bit_idx_t'(DATA_BITS - 1));

    assign bus.tx_ready = w_idle;
    assign busy         = ~w_idle;
    assign tx           = r_tx;
    assign tx_done      = r_tx_done;

    // State register and per-frame configuration latch.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register and counters are plain flops, not a
            // memory array, so clearing them on reset costs nothing extra.
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_more <= 1'b0;
            r_tx        <= 1'b1;
            r_tx_done   <= 1'b0;
            r_div_m1    <= '0;
            r_stop2     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_shift     <= w_shift_next;
            r_bit_idx   <= w_bit_next;
            r_stop_more <= w_stop_more_next;
            r_tx        <= w_tx_next;
            r_tx_done   <= w_done_next;
            if (w_accept) begin
                r_div_m1  <= div_m1(bus.set_baud);
                r_stop2   <= bus.stop2;
`ifdef UART_TX_PARITY_EN
                r_par_en  <= (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                r_par_bit <= (^bus.tx_data) ^ (bus.parity_mode == 2'b10);
`endif
            end
        end
    end

    // Next-state and registered-output logic. w_tx_next is the line level for
    // the coming cycle, which is why each transition loads the next bit.
    // NOTE: every output of this block is assigned a default first so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_shift_next     = r_shift;
        w_bit_next       = r_bit_idx;
        w_stop_more_next = r_stop_more;
        w_tx_next        = r_tx;
        w_done_next      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (bus.tx_valid) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                    w_shift_next = bus.tx_data;
                    w_tx_next    = 1'b0;
                end
            end

            S_START: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                end
            end

            S_DATA: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (w_last_data) begin
`ifdef UART_TX_PARITY_EN
                        if (r_par_en) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = r_par_bit;
                        end else begin
                            w_state_next     = S_STOP;
                            w_tx_next        = 1'b1;
                            w_stop_more_next = r_stop2;
                        end
`else
                        w_state_next     = S_STOP;
                        w_tx_next        = 1'b1;
                        w_stop_more_next = r_stop2;
`endif
                    end else begin
                        w_bit_next   = r_bit_idx + 1'b1;
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_state_next     = S_STOP;
                    w_cnt_next       = '0;
                    w_tx_next        = 1'b1;
                    w_stop_more_next = r_stop2;
                end
            end
`endif

            S_STOP: begin
                w_cnt_next = r_cnt + 1'b1;
                w_tx_next  = 1'b1;
                if (r_stop_more) begin
                    if (w_bit_end) begin
                        w_cnt_next       = '0;
                        w_stop_more_next = 1'b0;
                    end
                end else if (r_cnt == r_div_m1 - 1'b1) begin
                    // The final stop cycle is the IDLE/tx_done cycle, so leave
                    // one count early to allow a gapless next frame.
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

endmodule
